// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_issue_stage
// Description : RV32I shift issue stage. Decodes and validates the shift
//               encoding, then registers shifter controls through a 2-entry
//               skid buffer so that o_ready never depends on i_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_issue_stage #(
  parameter int RD_W  = 5,
  parameter int TAG_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic              i_is_imm,
  input  logic [31:0]       i_rs1_data,
  input  logic [31:0]       i_rs2_data,
  input  logic [4:0]        i_shamt,
  input  logic [RD_W-1:0]   i_rd,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_in,
  output logic [4:0]        o_amt,
  output logic              o_dir,
  output logic              o_arith,
  output logic              o_illegal,
  output logic [RD_W-1:0]   o_rd,
  output logic [TAG_W-1:0]  o_tag
);

  typedef struct packed {
    logic [31:0]      in;
    logic [4:0]       amt;
    logic             dir;
    logic             arith;
    logic             illegal;
    logic [RD_W-1:0]  rd;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic   w_is_sll;
  logic   w_is_sr;
  logic   w_legal;
  logic   w_accept;
  logic   w_emit;
  logic   w_unused_rs2;
  entry_t w_entry;

  entry_t out_q,  out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q,  out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_q,      ready_d;

  // Only rs2[4:0] matters for RV32 register-form shift amounts.
  assign w_unused_rs2 = ^i_rs2_data[31:5];

  // funct7[0] doubles as shamt[5] in immediate form, so the exact-match
  // check on funct7 also rejects RV32 shift amounts >= 32.
  assign w_is_sll = (i_funct3 == 3'b001);
  assign w_is_sr  = (i_funct3 == 3'b101);
  assign w_legal  = (w_is_sll && (i_funct7 == 7'b0000000)) ||
                    (w_is_sr  && ((i_funct7 == 7'b0000000) ||
                                  (i_funct7 == 7'b0100000)));

  always_comb begin
    w_entry         = '0;
    w_entry.in      = i_rs1_data;
    w_entry.rd      = i_rd;
    w_entry.tag     = i_tag;
    w_entry.illegal = !w_legal;
    if (w_legal) begin
      w_entry.amt   = i_is_imm ? i_shamt : i_rs2_data[4:0];
      w_entry.dir   = w_is_sr;
      w_entry.arith = w_is_sr && i_funct7[5];
    end
  end

  assign w_accept = i_valid && ready_q;
  assign w_emit   = out_valid_q && i_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || w_emit) begin
      // SKID always drains ahead of new input to preserve ordering.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        out_d       = w_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_d       = w_entry;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = out_valid_q;
  assign o_in      = out_q.in;
  assign o_amt     = out_q.amt;
  assign o_dir     = out_q.dir;
  assign o_arith   = out_q.arith;
  assign o_illegal = out_q.illegal;
  assign o_rd      = out_q.rd;
  assign o_tag     = out_q.tag;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_issue_stage
// Description : Scoreboard bench for shift_issue_stage; the monitor tracks
//               accepted instructions in a queue and checks every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_issue_stage;

  localparam int RD_W  = 5;
  localparam int TAG_W = 4;
  localparam int EW    = 32 + 5 + 3 + RD_W + TAG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       funct3 = '0;
  logic [6:0]       funct7 = '0;
  logic             is_imm = 1'b0;
  logic [31:0]      rs1 = '0;
  logic [31:0]      rs2 = '0;
  logic [4:0]       shamt = '0;
  logic [RD_W-1:0]  rd = '0;
  logic [TAG_W-1:0] tag = '0;

  logic             o_ready, o_valid, o_dir, o_arith, o_illegal;
  logic [31:0]      o_in;
  logic [4:0]       o_amt;
  logic [RD_W-1:0]  o_rd;
  logic [TAG_W-1:0] o_tag;

  int checks = 0;
  int errors = 0;

  shift_issue_stage #(.RD_W(RD_W), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid),
    .o_ready(o_ready), .i_funct3(funct3), .i_funct7(funct7),
    .i_is_imm(is_imm), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .i_shamt(shamt), .i_rd(rd), .i_tag(tag), .o_valid(o_valid),
    .i_ready(out_ready), .o_in(o_in), .o_amt(o_amt), .o_dir(o_dir),
    .o_arith(o_arith), .o_illegal(o_illegal), .o_rd(o_rd), .o_tag(o_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: expected entry straight from the RV32I shift encoding rules.
  function automatic logic [EW-1:0] model(
      input logic [2:0] f3, input logic [6:0] f7, input logic imm,
      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
      input logic [RD_W-1:0] d, input logic [TAG_W-1:0] t);
    logic legal, dr, ar;
    logic [4:0] amount;
    legal  = (f3 == 3'd1 && f7 == 7'd0) ||
             (f3 == 3'd5 && (f7 == 7'd0 || f7 == 7'd32));
    amount = 5'd0; dr = 1'b0; ar = 1'b0;
    if (legal) begin
      amount = imm ? sh : 5'(b % 32);
      dr     = (f3 == 3'd5);
      ar     = (f3 == 3'd5) && (f7 == 7'd32);
    end
    return {a, amount, dr, ar, !legal, d, t};
  endfunction

  // Monitor / scoreboard
  logic [EW-1:0] sb[$];
  bit started = 0;
  bit was_rst = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("o_ready", 64'(o_ready), 64'(sb.size() < 2));
      chk("o_valid", 64'(o_valid), 64'(sb.size() != 0));
      if (o_valid && sb.size() != 0)
        chk("entry", 64'({o_in, o_amt, o_dir, o_arith, o_illegal, o_rd, o_tag}), 64'(sb[0]));
      if (was_rst)
        chk("reset_outputs", 64'({o_in, o_amt, o_dir, o_arith, o_illegal, o_rd, o_tag}), 64'(0));
    end
    if (rst) begin
      sb.delete();
      started = 1;
      was_rst = 1;
    end else begin
      was_rst = 0;
      if (started) begin
        if (o_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
        if (flush) sb.delete();
        else if (in_valid && o_ready)
          sb.push_back(model(funct3, funct7, is_imm, rs1, rs2, shamt, rd, tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    funct3 = f3; funct7 = f7; is_imm = imm;
    rs1 = a; rs2 = b; shamt = sh;
    rd = RD_W'($urandom); tag = t;
  endtask

  // Hold the current input until accepted; returns cycles taken.
  task automatic wait_accept(output int used);
    logic acc;
    used = 0;
    for (int n = 0; n < 20; n++) begin
      acc = o_ready;
      tick();
      used++;
      if (acc) return;
    end
    errors++;
    $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
  endtask

  task automatic offer(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [TAG_W-1:0] t);
    int used;
    set_in(f3, f7, imm, a, b, sh, t);
    wait_accept(used);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int used;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // SRAI by 4 on 0x80000000
    offer(3'b101, 7'b0100000, 1'b1, 32'h8000_0000, 32'h0, 5'd4, 4'd0);
    idle(2);

    // SLL register form, 8 back-to-back
    for (int i = 0; i < 8; i++)
      offer(3'b001, 7'b0, 1'b0, $urandom, 32'hFFFF_FFE3, 5'($urandom), 4'(i));
    idle(3);

    // Backpressure: tags 1,2 captured, tag 3 held upstream
    out_ready = 1'b0;
    offer(3'b101, 7'b0, 1'b0, $urandom, $urandom, 5'd0, 4'd1);
    offer(3'b101, 7'b0100000, 1'b1, $urandom, $urandom, 5'd9, 4'd2);
    set_in(3'b001, 7'b0, 1'b1, $urandom, $urandom, 5'd31, 4'd3);
    tick(); tick(); tick();
    chk("stall_ready", 64'(o_ready), 64'(0));
    out_ready = 1'b1;
    wait_accept(used);
    idle(4);

    // Illegal encodings
    offer(3'b001, 7'b0100000, 1'b1, $urandom, $urandom, 5'd7, 4'd4);
    offer(3'b101, 7'b0000001, 1'b1, $urandom, $urandom, 5'd7, 4'd5);
    offer(3'b010, 7'b0, 1'b0, $urandom, $urandom, 5'd7, 4'd6);
    idle(3);

    // Flush with both entries full and concurrent input
    out_ready = 1'b0;
    offer(3'b001, 7'b0, 1'b0, $urandom, $urandom, 5'd1, 4'd7);
    offer(3'b001, 7'b0, 1'b0, $urandom, $urandom, 5'd2, 4'd8);
    set_in(3'b101, 7'b0, 1'b1, $urandom, $urandom, 5'd3, 4'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Reset with flush mid-stall, then immediate accept
    out_ready = 1'b0;
    offer(3'b101, 7'b0, 1'b0, $urandom, $urandom, 5'd1, 4'd10);
    offer(3'b101, 7'b0, 1'b0, $urandom, $urandom, 5'd2, 4'd11);
    in_valid = 1'b0;
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    set_in(3'b001, 7'b0, 1'b0, 32'h1234_5678, 32'h5, 5'd0, 4'd12);
    wait_accept(used);
    chk("accept_after_reset", 64'(used), 64'(1));
    out_ready = 1'b1;
    idle(3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] f3;
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0:       f3 = 3'b001;
        1, 2:    f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       f7 = 7'b0100000;
        1, 2:    f7 = 7'b0;
        default: f7 = 7'($urandom);
      endcase
      set_in(f3, f7, 1'($urandom), $urandom, $urandom, 5'($urandom), 4'($urandom));
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(5);
    chk("drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
Issue stage directly upstream of the execute-stage variable shifter. It accepts decoded RV32I shift instructions (SLL/SRL/SRA/SLLI/SRLI/SRAI) from decode over a valid/ready handshake, validates the encoding and derives the shifter controls (operand, amount, direction, arithmetic). It presents these as registered outputs through a 2-entry skid buffer, so backpressure from execute never creates a combinational ready path back to decode.

Parameters:
RD_W, 5, destination register index width
TAG_W, 4, opaque instruction tag width, passed through untouched

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_flush  in  1  pipeline flush (branch mispredict/trap); drops all held entries
i_valid  in  1  decode has an instruction
o_ready  out  1  stage can accept this cycle (registered)
i_funct3  in  3  instruction funct3
i_funct7  in  7  instruction[31:25]
i_is_imm  in  1  1 = immediate form (OP-IMM), 0 = register form (OP)
i_rs1_data  in  32  shift source operand
i_rs2_data  in  32  register shift amount source
i_shamt  in  5  instruction[24:20] (immediate shift amount)
i_rd  in  RD_W  destination register
i_tag  in  TAG_W  instruction tag
o_valid  out  1  output entry valid
i_ready  in  1  execute accepts the output entry
o_in  out  32  shifter data input
o_amt  out  5  shifter amount
o_dir  out  1  0 = left, 1 = right
o_arith  out  1  0 = logical, 1 = arithmetic
o_illegal  out  1  encoding not a legal RV32I shift
o_rd  out  RD_W  destination register
o_tag  out  TAG_W  tag

Behaviour:
- Accept = i_valid && o_ready; emit = o_valid && i_ready.
- Decode, computed on input and captured with the entry:
  - amt = i_is_imm ? i_shamt : i_rs2_data[4:0] (rs2 bits 31:5 ignored).
  - funct3 001: dir=0, arith=0.
  - funct3 101: dir=1, arith=i_funct7[5].
  - illegal if any of: funct3 not in {001,101}; i_funct7 not in {0000000,0100000}; funct3=001 with i_funct7[5]=1. i_funct7[0] is shamt[5] in immediate form, so RV32 shamt>=32 is illegal.
  - Illegal entries still flow through with o_illegal=1 and o_amt/o_dir/o_arith forced to 0. o_in, o_rd and o_tag are passed as received.
- Storage: output register (OUT) plus skid register (SKID). o_ready = !skid_valid, driven from a flop.
- Per-cycle update when not flushing:
  - OUT empty or emitting: OUT loads SKID if skid_valid (SKID clears), else loads the accepted input if any, else OUT clears.
  - OUT full and not emitting, with an accept: input goes to SKID. Legal only when SKID is empty, which o_ready guarantees.
  - SKID full, emitting, and an accept in the same cycle cannot occur, because o_ready=0 that cycle.
- Latency: an accepted instruction appears on o_* the next cycle if OUT is empty or emitting that cycle. Throughput is 1 per cycle with i_ready held high.
- Ordering: strict FIFO; SKID always drains to OUT before new input.
- Outputs are stable while o_valid && !i_ready.
- i_flush: next cycle o_valid=0, skid_valid=0, o_ready=1. Flush beats a simultaneous accept (input dropped) and a simultaneous emit (the emit still counts for execute that cycle).
- i_rst: dominates flush. Next cycle o_valid=0, o_ready=1, and o_in, o_amt, o_dir, o_arith, o_illegal, o_rd, o_tag all 0. Reset mid-stall discards both entries.
- No internal multicycle operation; the shifter itself is combinational downstream.

Test Plan:
1. Reset then stream SRAI (funct3=101, funct7=0100000, is_imm=1, shamt=4, rs1=0x80000000), i_ready=1 -> one cycle later o_valid=1, o_in=0x80000000, o_amt=4, o_dir=1, o_arith=1, o_illegal=0.
2. SLL register form with rs2=0xFFFFFFE3 -> o_amt=3, o_dir=0, o_arith=0. Back-to-back 8 instructions give 8 consecutive o_valid cycles in order by tag.
3. Backpressure: i_ready=0 with 3 offered instructions (tags 1,2,3) -> tags 1,2 captured, o_ready=0 after the second accept, tag 3 held upstream. Release i_ready -> tags emitted 1,2,3 with no gaps or duplicates and stable outputs during the stall.
4. Illegal encodings: SLLI with funct7=0100000; SRLI with funct7=0000001 (shamt bit5); funct3=010 -> each emerges with o_illegal=1 and o_amt=0.
5. Flush with both entries full and a concurrent i_valid -> next cycle o_valid=0 and o_ready=1, and the concurrent input never appears on the output.
6. Assert i_rst for 1 cycle mid-stall with i_flush=1 -> all outputs 0 and o_ready=1 next cycle. A new instruction is accepted the cycle after.
